// File: rtl/branch_predict_ctrl_if.sv
// Fetch-side prediction and execute-side resolution signals of the branch predictor.
// The slave modport is the predictor's view of these signals; the master modport is the pipeline's view.
interface branch_predict_ctrl_if;
    logic        iFetchValid;
    logic [31:0] iFetchPC;
    logic [31:0] iFetchImm;
    logic        oPredTaken;
    logic [31:0] oPredPC;
    logic        iExValid;
    logic        iExIsBranch;
    logic [31:0] iExPC;
    logic        iExPredTaken;
    logic        iExTaken;
    logic [31:0] iExTarget;
    logic        oRedirect;
    logic [31:0] oRedirectPC;
    logic        oFlush;
    logic [15:0] oBranchCount;
    logic [15:0] oMispredCount;

    modport slave (
        input  iFetchValid, iFetchPC, iFetchImm,
        input  iExValid, iExIsBranch, iExPC, iExPredTaken, iExTaken, iExTarget,
        output oPredTaken, oPredPC, oRedirect, oRedirectPC, oFlush,
        output oBranchCount, oMispredCount
    );

    modport master (
        output iFetchValid, iFetchPC, iFetchImm,
        output iExValid, iExIsBranch, iExPC, iExPredTaken, iExTaken, iExTarget,
        input  oPredTaken, oPredPC, oRedirect, oRedirectPC, oFlush,
        input  oBranchCount, oMispredCount
    );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Bimodal branch predictor: a table of 2-bit saturating counters, trained at execute,
// with a registered redirect strobe and a fixed-length flush window after each mispredict.
module branch_predict_ctrl #(
    parameter int BHT_BITS     = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input logic                  iCLK,
    input logic                  iRST,
    branch_predict_ctrl_if.slave bus
);
    localparam int         BHT_ENTRIES = 1 << BHT_BITS;
    localparam logic [3:0] FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [1:0]          bht_q [BHT_ENTRIES];
    logic [1:0]          bht_d [BHT_ENTRIES];
    logic [3:0]          flush_cnt_q, flush_cnt_d;
    logic                redirect_q, redirect_d;
    logic [31:0]         redirect_pc_q, redirect_pc_d;
    logic                flush_q, flush_d;
    logic [15:0]         branch_cnt_q, branch_cnt_d;
    logic [15:0]         mispred_cnt_q, mispred_cnt_d;
    logic [BHT_BITS-1:0] fetch_idx_s, ex_idx_s;
    logic                pred_taken_s, resolve_s, mispred_s;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        else       nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        return nxt;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? 16'hFFFF : val + 16'd1;
    endfunction

    assign fetch_idx_s = bus.iFetchPC[BHT_BITS+1:2];
    assign ex_idx_s    = bus.iExPC[BHT_BITS+1:2];
    assign resolve_s   = bus.iExValid & bus.iExIsBranch & (state_q == ST_IDLE);
    assign mispred_s   = resolve_s & (bus.iExTaken != bus.iExPredTaken);

    // Prediction reads the registered table, so a same-cycle execute update is not yet visible.
    always_comb begin
        pred_taken_s = bus.iFetchValid & bht_q[fetch_idx_s][1];
        if (pred_taken_s) bus.oPredPC = bus.iFetchPC + bus.iFetchImm;
        else              bus.oPredPC = bus.iFetchPC + 32'd4;
    end

    assign bus.oPredTaken    = pred_taken_s;
    assign bus.oRedirect     = redirect_q;
    assign bus.oRedirectPC   = redirect_pc_q;
    assign bus.oFlush        = flush_q;
    assign bus.oBranchCount  = branch_cnt_q;
    assign bus.oMispredCount = mispred_cnt_q;

    // Next-state: resolve and train in IDLE, count down the flush window in FLUSH.
    always_comb begin
        state_d       = state_q;
        bht_d         = bht_q;
        flush_cnt_d   = flush_cnt_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        flush_d       = flush_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (resolve_s) begin
                    bht_d[ex_idx_s] = sat_update(bht_q[ex_idx_s], bus.iExTaken);
                    branch_cnt_d    = sat_inc16(branch_cnt_q);
                end else begin
                    branch_cnt_d = branch_cnt_q;
                end
                if (mispred_s) begin
                    redirect_d    = 1'b1;
                    redirect_pc_d = bus.iExTaken ? bus.iExTarget : bus.iExPC + 32'd4;
                    mispred_cnt_d = sat_inc16(mispred_cnt_q);
                    state_d       = ST_FLUSH;
                    flush_d       = 1'b1;
                    flush_cnt_d   = FLUSH_LOAD;
                end else begin
                    flush_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                    flush_d = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                flush_d = 1'b0;
            end
        endcase
    end

    // State, table and output registers.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q       <= ST_IDLE;
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
            flush_cnt_q   <= 4'd0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            flush_q       <= 1'b0;
            branch_cnt_q  <= 16'd0;
            mispred_cnt_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            bht_q         <= bht_d;
            flush_cnt_q   <= flush_cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            flush_q       <= flush_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end
endmodule

// File: doc/branch_predict_ctrl.md
BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 SHALL have parameter BHT_BITS, default 4, log2 of branch-history-table entries.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, cycles oFlush is held per mispredict (legal 1..15).
REQ-003 SHALL have port iCLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port iRST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port iFetchValid  input  1  fetch-stage instruction is a valid conditional branch.
REQ-006 SHALL have port iFetchPC  input  32  fetch-stage PC.
REQ-007 SHALL have port iFetchImm  input  32  sign-extended B-type immediate of the fetch instruction.
REQ-008 SHALL have port oPredTaken  output  1  prediction for the fetch branch.
REQ-009 SHALL have port oPredPC  output  32  predicted next PC.
REQ-010 SHALL have port iExValid  input  1  execute-stage instruction valid.
REQ-011 SHALL have port iExIsBranch  input  1  execute instruction is a conditional branch.
REQ-012 SHALL have port iExPC  input  32  execute-stage PC.
REQ-013 SHALL have port iExPredTaken  input  1  prediction carried down the pipeline with the branch.
REQ-014 SHALL have port iExTaken  input  1  actual outcome from the branch evaluator.
REQ-015 SHALL have port iExTarget  input  32  computed branch target (PC+imm).
REQ-016 SHALL have port oRedirect  output  1  one-cycle PC-redirect strobe.
REQ-017 SHALL have port oRedirectPC  output  32  corrected PC, valid while oRedirect=1.
REQ-018 SHALL have port oFlush  output  1  squash younger pipeline stages.
REQ-019 SHALL have ports oBranchCount and oMispredCount  output  16 each  resolved-branch and mispredict counters.

Function
REQ-020 SHALL hold 2^BHT_BITS 2-bit saturating counters, indexed by PC[BHT_BITS+1:2] for both fetch and execute.
REQ-021 SHALL drive oPredTaken = iFetchValid AND counter[idx][1], combinationally.
REQ-022 SHALL drive oPredPC = iFetchPC+iFetchImm when oPredTaken=1, else iFetchPC+4, 32-bit wrap-around.
REQ-023 SHALL have states IDLE and FLUSH; resolution ("resolve") occurs only when iExValid=1, iExIsBranch=1 and state=IDLE.
REQ-024 On resolve SHALL update the indexed counter: increment if iExTaken=1 (saturate at 3), else decrement (saturate at 0).
REQ-025 On resolve SHALL increment oBranchCount, saturating at 16'hFFFF.
REQ-026 Mispredict = resolve AND (iExTaken != iExPredTaken).
REQ-027 On mispredict, next cycle SHALL assert oRedirect for exactly 1 cycle with oRedirectPC = iExTarget if taken, else iExPC+4 (registered).
REQ-028 On mispredict SHALL enter FLUSH and hold oFlush=1 for exactly FLUSH_CYCLES cycles, starting the same cycle as oRedirect, then return to IDLE.
REQ-029 On mispredict SHALL increment oMispredCount, saturating at 16'hFFFF.
REQ-030 In FLUSH, execute-stage inputs SHALL be ignored: no counter, table or redirect update.
REQ-031 Same-cycle fetch read and execute write of one index: prediction SHALL use the pre-update value.
REQ-032 iExValid=0 or iExIsBranch=0 SHALL cause no state change.
REQ-033 oRedirectPC SHALL hold its last value when oRedirect=0.

Reset
REQ-034 iRST=0 SHALL immediately force state IDLE, every counter to 2'b01, oRedirect=0, oFlush=0, oRedirectPC=0, oBranchCount=0, oMispredCount=0.
REQ-035 Reset asserted mid-FLUSH SHALL abort the flush with no residual oFlush or oRedirect after release.
REQ-036 First resolve SHALL be accepted on the first rising edge after iRST deasserts.

Verification
REQ-037 After reset, iFetchValid=1, PC=0x100, imm=0x20 -> oPredTaken=0, oPredPC=0x104.
REQ-038 Two taken resolves at PC=0x100 (pred 0) -> first mispredicts: oRedirect 1 cycle, oRedirectPC=target, oFlush 2 cycles, oMispredCount=1; second resolve (pred 0) issued after FLUSH also mispredicts; fetch at 0x100 then predicts taken, oPredPC=0x120.
REQ-039 Resolve arriving during FLUSH -> ignored; oBranchCount unchanged, no oRedirect.
REQ-040 Four not-taken resolves at one index -> counter saturates at 0, no mispredicts once prediction matches; others indices still 01.
REQ-041 Same-cycle fetch/resolve on index 5 with counter 01 and taken outcome -> oPredTaken=0 that cycle, 1 next cycle.
REQ-042 iRST low during second FLUSH cycle -> oFlush=0 immediately, counters 0, table 01 after release.
